// File: rtl/gac_regfile_wr_32x32_if.sv
// Write-port bundle for the 32x32 register bank: valid/ready handshake with address and data.
interface gac_regfile_wr_32x32_if #(
   parameter int DATA_W = 32
);
   logic              wr_valid;
   logic              wr_ready;
   logic [4:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/gac_regfile_wr_32x32.sv
// Write side of the 32-entry register bank: one-hot write decode, write ack/count,
// and a clear sweep that zeroes registers 1..31 one per cycle.
module gac_regfile_wr_32x32 #(
   parameter int DATA_W   = 32,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   gac_regfile_wr_32x32_if.slave  wr,
   input  logic                   clr_req,
   output logic                   busy,
   output logic                   wr_ack,
   output logic [15:0]            wr_cnt,
   output logic [32*DATA_W-1:0]   regs_flat
);

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   localparam logic [31:0] WE_MASK = ZERO_REG ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        ready_c;
   logic        accept;
   logic [31:0] we;
   logic [31:0] clr_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ready_c = 1'b0;
      clr_en  = 32'd0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (clr_req) begin
               state_d = SWEEP;
               idx_d   = 5'd1;
            end
         end
         SWEEP: begin
            clr_en = 32'd1 << idx_q;
            if (idx_q == 5'd31) begin
               state_d = IDLE;
               idx_d   = 5'd0;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 5'd0;
         end
      endcase
   end

   assign wr.wr_ready = ready_c;
   assign busy        = (state_q == SWEEP);
   assign accept      = wr.wr_valid & ready_c;
   assign we          = accept ? ((32'd1 << wr.wr_addr) & WE_MASK) : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ack <= 1'b0;
         wr_cnt <= 16'd0;
      end else begin
         wr_ack <= accept;
         if (accept) wr_cnt <= wr_cnt + 16'd1;
      end
   end

   // Writes only happen in IDLE and clears only in SWEEP, so the enables never overlap.
   for (genvar i = 0; i < 32; i++) begin : g_reg
      logic [DATA_W-1:0] r;
      always_ff @(posedge clk) begin
         if (reset)          r <= '0;
         else if (we[i])     r <= wr.wr_data;
         else if (clr_en[i]) r <= '0;
      end
      assign regs_flat[i*DATA_W +: DATA_W] = r;
   end

endmodule

// File: tb/tb_gac_regfile_wr_32x32.sv
// Directed bench for gac_regfile_wr_32x32: write table, back-to-back fill, clear sweeps,
// reset mid-sweep and write-counter wrap.
module tb_gac_regfile_wr_32x32;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr_req;
   logic        busy;
   logic        wr_ack;
   logic [15:0] wr_cnt;
   logic [1023:0] regs_flat;

   int checks = 0;
   int errors = 0;

   gac_regfile_wr_32x32_if #(.DATA_W(32)) wif ();

   gac_regfile_wr_32x32 #(.DATA_W(32), .ZERO_REG(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr        (wif),
      .clr_req   (clr_req),
      .busy      (busy),
      .wr_ack    (wr_ack),
      .wr_cnt    (wr_cnt),
      .regs_flat (regs_flat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_val;
   } wvec_t;

   wvec_t vec [6];

   function automatic logic [31:0] rd(input int i);
      return regs_flat[i*32 +: 32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string name);
      for (int k = 0; k < 32; k++) chk($sformatf("%s_r%0d", name, k), rd(k), 32'd0);
   endtask

   initial begin
      logic [15:0] cnt_exp;
      reset        = 1'b1;
      clr_req      = 1'b0;
      wif.wr_valid = 1'b0;
      wif.wr_addr  = 5'd0;
      wif.wr_data  = 32'd0;

      vec[0] = '{5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vec[1] = '{5'd0,  32'h12345678, 32'h00000000};
      vec[2] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vec[3] = '{5'd1,  32'h00000001, 32'h00000001};
      vec[4] = '{5'd5,  32'hCAFEF00D, 32'hCAFEF00D};
      vec[5] = '{5'd16, 32'h80000000, 32'h80000000};

      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, wif.wr_ready}, 32'd1);
      chk("rst_ack", {31'd0, wr_ack}, 32'd0);
      chk("rst_cnt", {16'd0, wr_cnt}, 32'd0);
      chk_all_zero("rst");

      // Single writes from the table, each followed by an idle cycle.
      cnt_exp = 16'd0;
      for (int v = 0; v < 6; v++) begin
         wif.wr_valid = 1'b1;
         wif.wr_addr  = vec[v].addr;
         wif.wr_data  = vec[v].data;
         chk($sformatf("v%0d_ready", v), {31'd0, wif.wr_ready}, 32'd1);
         tick();
         wif.wr_valid = 1'b0;
         wif.wr_data  = 32'hXXXXXXXX;
         cnt_exp++;
         chk($sformatf("v%0d_val", v), rd(int'(vec[v].addr)), vec[v].exp_val);
         chk($sformatf("v%0d_ack", v), {31'd0, wr_ack}, 32'd1);
         chk($sformatf("v%0d_cnt", v), {16'd0, wr_cnt}, {16'd0, cnt_exp});
         if (v == 0) begin
            for (int k = 0; k < 32; k++)
               if (k != 5) chk($sformatf("v0_other_r%0d", k), rd(k), 32'd0);
         end
         tick();
         chk($sformatf("v%0d_ack_low", v), {31'd0, wr_ack}, 32'd0);
      end
      chk("r0_zero", rd(0), 32'd0);

      // Back-to-back fill of regs 1..31 with their index.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 1; i < 32; i++) begin
         wif.wr_valid = 1'b1;
         wif.wr_addr  = 5'(i);
         wif.wr_data  = 32'(i);
         tick();
         chk($sformatf("fill_r%0d", i), rd(i), 32'(i));
         chk($sformatf("fill_ack%0d", i), {31'd0, wr_ack}, 32'd1);
         if (i < 31) chk($sformatf("fill_next_r%0d", i + 1), rd(i + 1), 32'd0);
      end
      wif.wr_valid = 1'b0;
      chk("fill_cnt", {16'd0, wr_cnt}, 32'd31);
      tick();
      chk("fill_ack_end", {31'd0, wr_ack}, 32'd0);

      // Clear sweep: register k reads zero from cycle k+1 after the request.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 1; c <= 31; c++) begin
         chk($sformatf("sw_busy%0d", c), {31'd0, busy}, 32'd1);
         chk($sformatf("sw_ready%0d", c), {31'd0, wif.wr_ready}, 32'd0);
         chk($sformatf("sw_cur_r%0d", c), rd(c), 32'(c));
         if (c > 1) chk($sformatf("sw_prev_r%0d", c - 1), rd(c - 1), 32'd0);
         tick();
      end
      chk("sw_end_busy", {31'd0, busy}, 32'd0);
      chk("sw_end_ready", {31'd0, wif.wr_ready}, 32'd1);
      chk_all_zero("sw_end");
      chk("sw_cnt", {16'd0, wr_cnt}, 32'd31);

      // Write held through a sweep, with a stray clr_req mid-sweep.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 5'd7;
      wif.wr_data  = 32'hA5A5A5A5;
      for (int c = 1; c <= 31; c++) begin
         clr_req = (c == 12);
         chk($sformatf("hold_busy%0d", c), {31'd0, busy}, 32'd1);
         chk($sformatf("hold_cnt%0d", c), {16'd0, wr_cnt}, 32'd31);
         tick();
         chk($sformatf("hold_r7_%0d", c), rd(7), 32'd0);
      end
      clr_req = 1'b0;
      chk("hold_ready", {31'd0, wif.wr_ready}, 32'd1);
      chk("hold_no_restart", {31'd0, busy}, 32'd0);
      tick();
      wif.wr_valid = 1'b0;
      chk("hold_r7", rd(7), 32'hA5A5A5A5);
      chk("hold_ack", {31'd0, wr_ack}, 32'd1);
      chk("hold_cnt", {16'd0, wr_cnt}, 32'd32);

      // Write and clear request in the same IDLE cycle.
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 5'd4;
      wif.wr_data  = 32'h00000044;
      clr_req      = 1'b1;
      tick();
      wif.wr_valid = 1'b0;
      clr_req      = 1'b0;
      chk("both_r4", rd(4), 32'h00000044);
      chk("both_ack", {31'd0, wr_ack}, 32'd1);
      chk("both_busy", {31'd0, busy}, 32'd1);
      chk("both_cnt", {16'd0, wr_cnt}, 32'd33);
      for (int c = 1; c <= 31; c++) tick();
      chk("both_r4_clr", rd(4), 32'd0);
      chk("both_r7_clr", rd(7), 32'd0);
      chk("both_idle", {31'd0, busy}, 32'd0);

      // Reset at sweep cycle 10.
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 5'd20;
      wif.wr_data  = 32'h0000BEEF;
      tick();
      wif.wr_valid = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_r20", rd(20), 32'h0000BEEF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_ready", {31'd0, wif.wr_ready}, 32'd1);
      chk("mr_cnt", {16'd0, wr_cnt}, 32'd0);
      chk("mr_ack", {31'd0, wr_ack}, 32'd0);
      chk_all_zero("mr");
      tick();
      chk("mr_stays_idle", {31'd0, busy}, 32'd0);

      // Counter wrap after 65536 accepted writes.
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 5'd2;
      for (int n = 1; n <= 65535; n++) begin
         wif.wr_data = 32'(n);
         tick();
      end
      chk("wrap_ffff", {16'd0, wr_cnt}, 32'h0000FFFF);
      chk("wrap_r2", rd(2), 32'h0000FFFF);
      tick();
      wif.wr_valid = 1'b0;
      chk("wrap_zero", {16'd0, wr_cnt}, 32'd0);
      chk("wrap_ack", {31'd0, wr_ack}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gac_regfile_wr_32x32.md
Name: gac_regfile_wr_32x32

Overview:
- Write side of the 32-entry x 32-bit register bank; the complement of the 32-to-1 read muxes.
- Decodes a 5-bit write address into 32 one-hot register enables and accepts writes over a valid/ready handshake.
- Provides a commanded clear sweep FSM that zeroes registers 1..31 one per cycle.
- Exposes every register flattened so read muxes (x0..x1F) can tap it directly.

Parameters:
- DATA_W, 32, register width in bits.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  block can accept a write this cycle.
- wr_addr  input  5  destination register index.
- wr_data  input  DATA_W  write data.
- clr_req  input  1  single-cycle pulse; starts a clear sweep.
- busy  output  1  clear sweep in progress.
- wr_ack  output  1  registered pulse, one cycle after each accepted write, including writes to reg 0.
- wr_cnt  output  16  count of accepted writes, wrapping.
- regs_flat  output  32*DATA_W  register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (synchronous, active-high):
  - All 32 registers, wr_ack, wr_cnt, busy and the sweep index go to 0.
  - FSM enters IDLE. wr_ready is 1 in the first cycle after reset.
  - Reset asserted mid-sweep aborts the sweep and applies reset values.
- Write decode:
  - The address is decoded to a 32-bit one-hot enable, gated by the accept condition (wr_valid & wr_ready).
  - Register wr_addr takes wr_data at the clock edge of acceptance.
  - Write latency is 1 cycle: the new value is visible on regs_flat in the cycle after acceptance. There is no same-cycle bypass.
- Register 0: with ZERO_REG=1, a write to address 0 is accepted (ack, count) but the register stays 0.
- wr_ready = 1 exactly when the FSM is in IDLE. It is combinational from state only, never from wr_valid.
- FSM states:
  - IDLE:
    - clr_req=1 -> SWEEP with idx=1, and busy=1 from the next cycle.
    - If clr_req and wr_valid are both high in the same IDLE cycle, the write is accepted that cycle and the sweep starts next cycle. The sweep later clears that register again.
  - SWEEP:
    - Each cycle, register idx is cleared and idx increments.
    - When idx=31 is cleared -> IDLE.
    - The sweep lasts exactly 31 cycles; busy=1 throughout and wr_ready=0.
    - clr_req during SWEEP is ignored; it does not restart the sweep.
- wr_valid held during SWEEP: the request is not accepted and the requester must hold it. It is accepted in the first IDLE cycle.
- wr_cnt increments by 1 per accepted write and wraps 16'hFFFF -> 0.
- wr_ack is high for exactly one cycle per accepted write. Back-to-back accepted writes give consecutive ack cycles.
- wr_addr is 5 bits, so every value is in range.
- X on wr_addr or wr_data is permitted when wr_valid=0.

Test Plan:
- Reset, then write 32'hDEADBEEF to addr 5 with valid=1, ready=1 -> next cycle regs_flat[5*32+:32]=DEADBEEF, wr_ack=1 for one cycle, wr_cnt=1, all other registers 0.
- Write 32'h12345678 to addr 0 -> wr_ack=1, wr_cnt increments, register 0 stays 0.
- Fill regs 1..31 with value i back-to-back, one per cycle -> each visible one cycle after its write, wr_cnt=31, 31 consecutive ack cycles.
- Pulse clr_req with all registers nonzero -> busy and ready=0 for 31 cycles; register k reads 0 from cycle k+1 after clr_req; back to IDLE with all zero.
- Hold wr_valid (addr 7, data 0xA5A5A5A5) during a sweep -> not accepted while busy; accepted in the first IDLE cycle; reg 7 = A5A5A5A5 afterwards.
- Assert reset at sweep cycle 10 -> next cycle busy=0, ready=1, all registers 0, wr_cnt=0. Separately, 65536 writes -> wr_cnt wraps to 0.
